// File: rtl/tick_burst_generator.sv
// tick_burst_generator: emits a burst of pulses whose high/low widths are
// counted in divider ticks, so a slow programmable time base sets the timing.
// Optional feature: define TICK_BURST_LOOP_EN to add i_LOOP, which turns a
// finished burst into an endless repetition until abort or reset.
module tick_burst_generator #(
  parameter int unsigned TICK_W  = 16,
  parameter int unsigned COUNT_W = 16
) (
  input  logic               i_CLK,
  input  logic               i_RST_N,
  input  logic               i_TICK,
  input  logic               i_START,
  input  logic               i_ABORT,
`ifdef TICK_BURST_LOOP_EN
  input  logic               i_LOOP,
`endif
  input  logic [TICK_W-1:0]  i_HIGH_TICKS,
  input  logic [TICK_W-1:0]  i_LOW_TICKS,
  input  logic [COUNT_W-1:0] i_PULSE_COUNT,
  output logic               o_PULSE,
  output logic               o_BUSY,
  output logic               o_DONE,
  output logic [COUNT_W-1:0] o_PULSES_LEFT
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ARM  = 2'd1,
    ST_HIGH = 2'd2,
    ST_LOW  = 2'd3
  } state_t;

  state_t             state;
  state_t             state_nxt;

  logic [TICK_W-1:0]  phase_cnt;
  logic [TICK_W-1:0]  phase_cnt_nxt;
  logic [TICK_W-1:0]  high_len;
  logic [TICK_W-1:0]  high_len_nxt;
  logic [TICK_W-1:0]  low_len;
  logic [TICK_W-1:0]  low_len_nxt;
  logic [COUNT_W-1:0] count_len;
  logic [COUNT_W-1:0] count_len_nxt;

  logic               pulse_nxt;
  logic               busy_nxt;
  logic               done_nxt;
  logic [COUNT_W-1:0] left_nxt;

  logic [TICK_W-1:0]  high_norm;
  logic [TICK_W-1:0]  low_norm;
  logic               high_last;
  logic               low_last;
  logic [COUNT_W-1:0] left_dec;
  logic               loop_en;

`ifdef TICK_BURST_LOOP_EN
  assign loop_en = i_LOOP;
`else
  assign loop_en = 1'b0;
`endif

  // Zero-length phases are promoted to one tick so a phase always ends.
  always_comb begin
    high_norm = (i_HIGH_TICKS == '0) ? TICK_W'(1) : i_HIGH_TICKS;
    low_norm  = (i_LOW_TICKS  == '0) ? TICK_W'(1) : i_LOW_TICKS;
  end

  // Phase-end detection and saturating pulse-count decrement.
  always_comb begin
    high_last = (phase_cnt == (high_len - TICK_W'(1)));
    low_last  = (phase_cnt == (low_len  - TICK_W'(1)));
    left_dec  = (o_PULSES_LEFT != '0) ? (o_PULSES_LEFT - COUNT_W'(1)) : '0;
  end

  // Next-state and next-output logic; abort overrides everything when busy.
  always_comb begin
    state_nxt     = state;
    phase_cnt_nxt = phase_cnt;
    high_len_nxt  = high_len;
    low_len_nxt   = low_len;
    count_len_nxt = count_len;
    pulse_nxt     = o_PULSE;
    busy_nxt      = o_BUSY;
    done_nxt      = 1'b0;
    left_nxt      = o_PULSES_LEFT;

    unique case (state)
      ST_IDLE: begin
        if (i_START && !i_ABORT) begin
          high_len_nxt  = high_norm;
          low_len_nxt   = low_norm;
          count_len_nxt = i_PULSE_COUNT;
          left_nxt      = i_PULSE_COUNT;
          phase_cnt_nxt = '0;
          if (i_PULSE_COUNT == '0) begin
            done_nxt = 1'b1;
          end else begin
            state_nxt = ST_ARM;
            busy_nxt  = 1'b1;
          end
        end
      end

      ST_ARM: begin
        if (i_TICK) begin
          state_nxt     = ST_HIGH;
          phase_cnt_nxt = '0;
          pulse_nxt     = 1'b1;
        end
      end

      ST_HIGH: begin
        if (i_TICK) begin
          if (high_last) begin
            phase_cnt_nxt = '0;
            pulse_nxt     = 1'b0;
            left_nxt      = left_dec;
            if (left_dec != '0) begin
              state_nxt = ST_LOW;
            end else if (loop_en) begin
              left_nxt  = count_len;
              state_nxt = ST_LOW;
            end else begin
              state_nxt = ST_IDLE;
              busy_nxt  = 1'b0;
              done_nxt  = 1'b1;
            end
          end else begin
            phase_cnt_nxt = phase_cnt + TICK_W'(1);
          end
        end
      end

      ST_LOW: begin
        if (i_TICK) begin
          if (low_last) begin
            state_nxt     = ST_HIGH;
            phase_cnt_nxt = '0;
            pulse_nxt     = 1'b1;
          end else begin
            phase_cnt_nxt = phase_cnt + TICK_W'(1);
          end
        end
      end

      default: begin
        state_nxt = ST_IDLE;
        pulse_nxt = 1'b0;
        busy_nxt  = 1'b0;
        left_nxt  = '0;
      end
    endcase

    if ((state != ST_IDLE) && i_ABORT) begin
      state_nxt     = ST_IDLE;
      phase_cnt_nxt = '0;
      pulse_nxt     = 1'b0;
      busy_nxt      = 1'b0;
      done_nxt      = 1'b0;
      left_nxt      = '0;
    end
  end

  // State, configuration and registered outputs.
  always_ff @(posedge i_CLK or negedge i_RST_N) begin
    if (!i_RST_N) begin
      state         <= ST_IDLE;
      phase_cnt     <= '0;
      high_len      <= TICK_W'(1);
      low_len       <= TICK_W'(1);
      count_len     <= '0;
      o_PULSE       <= 1'b0;
      o_BUSY        <= 1'b0;
      o_DONE        <= 1'b0;
      o_PULSES_LEFT <= '0;
    end else begin
      state         <= state_nxt;
      phase_cnt     <= phase_cnt_nxt;
      high_len      <= high_len_nxt;
      low_len       <= low_len_nxt;
      count_len     <= count_len_nxt;
      o_PULSE       <= pulse_nxt;
      o_BUSY        <= busy_nxt;
      o_DONE        <= done_nxt;
      o_PULSES_LEFT <= left_nxt;
    end
  end

endmodule
